// File: rtl/gray_monitor.sv
// Downstream checker/decoder for a Gray counter stream: converts to binary, validates
// forward single steps, counts wraps and latches the first illegal transition until Clear.
module gray_monitor #(
    parameter int unsigned WIDTH = 3,
    parameter int unsigned CNT_W = 8
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic [WIDTH-1:0] Gray,
    input  logic             OvfIn,
    input  logic             Clear,
    output logic [WIDTH-1:0] Bin,
    output logic             Valid,
    output logic             Step,
    output logic             Wrap,
    output logic [CNT_W-1:0] Cycles,
    output logic             Err,
    output logic [1:0]       ErrCode
);

    localparam logic [WIDTH-1:0] MaxCode = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0] OneStep = WIDTH'(1);

    typedef enum logic [1:0] {StSync, StTrack, StFault} state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] gray_q;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] d;
    int unsigned      h;
    logic             fwd_step;
    logic             is_wrap;

    logic             valid_d, step_d, wrap_d, err_d;
    logic [CNT_W-1:0] cycles_d;
    logic [1:0]       errcode_d;

    // Each binary bit is the XOR of all Gray bits at or above it.
    always_comb begin
        b = '0;
        for (int i = 0; i < int'(WIDTH); i++) begin
            b[i] = ^(Gray >> i);
        end
    end

    always_comb begin
        h        = $countones(Gray ^ gray_q);
        d        = b - Bin;
        fwd_step = (h == 1) && (d == OneStep);
        is_wrap  = fwd_step && (Bin == MaxCode);
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q <= StSync;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StSync:  state_d = StTrack;
            StTrack: begin
                if (h > 1 || (h == 1 && d != OneStep)) begin
                    state_d = StFault;
                end else if (is_wrap && !OvfIn) begin
                    state_d = StFault;
                end
            end
            StFault: state_d = StFault;
            default: state_d = StSync;
        endcase
        if (Clear) begin
            state_d = StSync;
        end
    end

    always_comb begin
        valid_d   = Valid;
        step_d    = 1'b0;
        wrap_d    = 1'b0;
        cycles_d  = Cycles;
        err_d     = Err;
        errcode_d = ErrCode;
        if (state_q == StSync) begin
            valid_d = 1'b1;
        end
        // Clear outranks any error seen in the same cycle and suppresses pulses while resyncing.
        if (Clear) begin
            err_d     = 1'b0;
            errcode_d = 2'b00;
        end else if (state_q == StTrack) begin
            if (fwd_step) begin
                step_d = 1'b1;
                if (is_wrap) begin
                    wrap_d = 1'b1;
                    if (Cycles != {CNT_W{1'b1}}) begin
                        cycles_d = Cycles + 1'b1;
                    end
                    if (!OvfIn) begin
                        err_d     = 1'b1;
                        errcode_d = 2'b11;
                    end
                end
            end else if (h > 1) begin
                err_d     = 1'b1;
                errcode_d = 2'b01;
            end else if (h == 1) begin
                err_d     = 1'b1;
                errcode_d = 2'b10;
            end
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            gray_q  <= '0;
            Bin     <= '0;
            Valid   <= 1'b0;
            Step    <= 1'b0;
            Wrap    <= 1'b0;
            Cycles  <= '0;
            Err     <= 1'b0;
            ErrCode <= 2'b00;
        end else begin
            gray_q  <= Gray;
            Bin     <= b;
            Valid   <= valid_d;
            Step    <= step_d;
            Wrap    <= wrap_d;
            Cycles  <= cycles_d;
            Err     <= err_d;
            ErrCode <= errcode_d;
        end
    end

endmodule

// File: tb/tb_gray_monitor.sv
// Table-driven bench for gray_monitor: directed vectors plus a hand-written wrap saturation
// and Clear-priority sequence on a narrow-counter instance.
module tb_gray_monitor;

    logic       Clk = 1'b0;
    logic       Reset = 1'b1;
    logic [2:0] Gray = 3'b000;
    logic       OvfIn = 1'b0;
    logic       Clear = 1'b0;

    logic [2:0] Bin, s_bin;
    logic       Valid, Step, Wrap, Err;
    logic       s_valid, s_step, s_wrap, s_err;
    logic [7:0] Cycles;
    logic [1:0] s_cycles;
    logic [1:0] ErrCode, s_errcode;

    gray_monitor #(.WIDTH(3), .CNT_W(8)) dut (
        .Clk(Clk), .Reset(Reset), .Gray(Gray), .OvfIn(OvfIn), .Clear(Clear),
        .Bin(Bin), .Valid(Valid), .Step(Step), .Wrap(Wrap), .Cycles(Cycles),
        .Err(Err), .ErrCode(ErrCode)
    );

    gray_monitor #(.WIDTH(3), .CNT_W(2)) dut_s (
        .Clk(Clk), .Reset(Reset), .Gray(Gray), .OvfIn(OvfIn), .Clear(Clear),
        .Bin(s_bin), .Valid(s_valid), .Step(s_step), .Wrap(s_wrap), .Cycles(s_cycles),
        .Err(s_err), .ErrCode(s_errcode)
    );

    always #5 Clk = ~Clk;

    typedef struct {
        bit         rst;
        logic [2:0] gray;
        bit         ovf;
        bit         clr;
        logic [2:0] bin;
        bit         valid;
        bit         step;
        bit         wrap;
        logic [7:0] cyc;
        bit         err;
        logic [1:0] ec;
    } vec_t;

    vec_t vecs[$];
    int   passed = 0;
    int   total = 0;

    function automatic vec_t mk(int g, int o, int c, int bn, int v, int s, int w, int cy,
                                int e, int ec);
        vec_t r;
        r.rst   = 1'b0;
        r.gray  = 3'(g);
        r.ovf   = 1'(o);
        r.clr   = 1'(c);
        r.bin   = 3'(bn);
        r.valid = 1'(v);
        r.step  = 1'(s);
        r.wrap  = 1'(w);
        r.cyc   = 8'(cy);
        r.err   = 1'(e);
        r.ec    = 2'(ec);
        return r;
    endfunction

    function automatic vec_t rst_row();
        vec_t r;
        r = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        r.rst = 1'b1;
        return r;
    endfunction

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic check_out(string tag, int bn, int v, int s, int w, int cy, int e, int ec);
        check({tag, ".bin"},     32'(Bin),     32'(bn));
        check({tag, ".valid"},   32'(Valid),   32'(v));
        check({tag, ".step"},    32'(Step),    32'(s));
        check({tag, ".wrap"},    32'(Wrap),    32'(w));
        check({tag, ".cycles"},  32'(Cycles),  32'(cy));
        check({tag, ".err"},     32'(Err),     32'(e));
        check({tag, ".errcode"}, 32'(ErrCode), 32'(ec));
    endtask

    task automatic apply(int g, int o, int c);
        Gray  = 3'(g);
        OvfIn = 1'(o);
        Clear = 1'(c);
        @(posedge Clk);
        #1;
    endtask

    // Reset is raised mid-cycle; outputs must clear with no clock edge.
    task automatic do_reset();
        @(posedge Clk);
        #3;
        Reset = 1'b1;
        #1;
        check_out("reset", 0, 0, 0, 0, 0, 0, 0);
        check("reset.s_cycles", 32'(s_cycles), 32'd0);
        #2;
        Gray  = 3'b000;
        OvfIn = 1'b0;
        Clear = 1'b0;
        Reset = 1'b0;
    endtask

    initial begin
        logic [2:0] sweep [7];
        sweep = '{3'b001, 3'b011, 3'b010, 3'b110, 3'b111, 3'b101, 3'b100};

        // Full sweep with OvfIn only on the wrap (and once early, which is legal).
        vecs.push_back(rst_row());
        vecs.push_back(mk(0, 0, 0, 0, 1, 0, 0, 0, 0, 0));
        vecs.push_back(mk(1, 0, 0, 1, 1, 1, 0, 0, 0, 0));
        vecs.push_back(mk(3, 1, 0, 2, 1, 1, 0, 0, 0, 0));
        vecs.push_back(mk(2, 0, 0, 3, 1, 1, 0, 0, 0, 0));
        vecs.push_back(mk(6, 0, 0, 4, 1, 1, 0, 0, 0, 0));
        vecs.push_back(mk(7, 0, 0, 5, 1, 1, 0, 0, 0, 0));
        vecs.push_back(mk(5, 0, 0, 6, 1, 1, 0, 0, 0, 0));
        vecs.push_back(mk(4, 0, 0, 7, 1, 1, 0, 0, 0, 0));
        vecs.push_back(mk(0, 1, 0, 0, 1, 1, 1, 1, 0, 0));
        vecs.push_back(mk(0, 1, 0, 0, 1, 0, 0, 1, 0, 0));
        // Multi-bit change, later errors ignored, frozen steps, Clear and resync.
        vecs.push_back(rst_row());
        vecs.push_back(mk(0, 0, 0, 0, 1, 0, 0, 0, 0, 0));
        vecs.push_back(mk(1, 0, 0, 1, 1, 1, 0, 0, 0, 0));
        vecs.push_back(mk(2, 0, 0, 3, 1, 0, 0, 0, 1, 1));
        vecs.push_back(mk(0, 0, 0, 0, 1, 0, 0, 0, 1, 1));
        vecs.push_back(mk(1, 0, 0, 1, 1, 0, 0, 0, 1, 1));
        vecs.push_back(mk(3, 0, 0, 2, 1, 0, 0, 0, 1, 1));
        vecs.push_back(mk(3, 0, 1, 2, 1, 0, 0, 0, 0, 0));
        vecs.push_back(mk(2, 0, 0, 3, 1, 0, 0, 0, 0, 0));
        vecs.push_back(mk(6, 0, 0, 4, 1, 1, 0, 0, 0, 0));
        // Backward single-bit change.
        vecs.push_back(rst_row());
        vecs.push_back(mk(0, 0, 0, 0, 1, 0, 0, 0, 0, 0));
        vecs.push_back(mk(1, 0, 0, 1, 1, 1, 0, 0, 0, 0));
        vecs.push_back(mk(3, 0, 0, 2, 1, 1, 0, 0, 0, 0));
        vecs.push_back(mk(1, 0, 0, 1, 1, 0, 0, 0, 1, 2));
        // Wrap without OvfIn: pulses and count still happen alongside the error.
        vecs.push_back(rst_row());
        vecs.push_back(mk(4, 0, 0, 7, 1, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 1, 1, 1, 1, 1, 3));
        vecs.push_back(mk(0, 0, 0, 0, 1, 0, 0, 1, 1, 3));

        #12;
        Reset = 1'b0;

        for (int i = 0; i < vecs.size(); i++) begin
            if (vecs[i].rst) begin
                do_reset();
            end else begin
                apply(int'(vecs[i].gray), int'(vecs[i].ovf), int'(vecs[i].clr));
                check_out($sformatf("v%0d", i), int'(vecs[i].bin), int'(vecs[i].valid),
                          int'(vecs[i].step), int'(vecs[i].wrap), int'(vecs[i].cyc),
                          int'(vecs[i].err), int'(vecs[i].ec));
            end
        end

        // Four legal wraps: 8-bit counter reaches 4, 2-bit counter saturates at 3.
        do_reset();
        apply(4, 1, 0);
        check_out("sat.sync", 7, 1, 0, 0, 0, 0, 0);
        for (int k = 1; k <= 4; k++) begin
            apply(0, 1, 0);
            check($sformatf("sat%0d.wrap", k), 32'(Wrap), 32'd1);
            check($sformatf("sat%0d.cycles", k), 32'(Cycles), 32'(k));
            check($sformatf("sat%0d.s_cycles", k), 32'(s_cycles), (k > 3) ? 32'd3 : 32'(k));
            check($sformatf("sat%0d.s_err", k), 32'(s_err), 32'd0);
            for (int j = 0; j < 7; j++) begin
                apply(int'(sweep[j]), 1, 0);
            end
            check($sformatf("sat%0d.bin", k), 32'(Bin), 32'd7);
        end

        // Illegal two-bit change 100 -> 111 with Clear in the same cycle.
        apply(7, 1, 1);
        check_out("clrpri", 5, 1, 0, 0, 4, 0, 0);
        check("clrpri.s_cycles", 32'(s_cycles), 32'd3);
        check("clrpri.s_err", 32'(s_err), 32'd0);
        apply(7, 1, 0);
        check_out("clrpri.sync", 5, 1, 0, 0, 4, 0, 0);
        apply(5, 1, 0);
        check_out("clrpri.step", 6, 1, 1, 0, 4, 0, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
